// File: rtl/led_matrix_scan_if.sv
// ---------------------------------------------------------------------------
// Module   : led_matrix_scan_if
// Purpose  : Bundles the pixel write port, the scan enable and the LED
//            drive outputs of led_matrix_scan.
// Signals  : enable      - scan enable (0 = idle/dark)
//            wr_en       - pixel write strobe
//            wr_row      - pixel row address
//            wr_col      - pixel column address
//            wr_data     - pixel brightness
//            ledc        - column (cathode) drive, active-high
//            leda        - row (anode) select, one-hot, active-high
//            frame_start - one-clk pulse at the start of each frame
// Modports : master - brightness producer side
//            slave  - the scanner
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface led_matrix_scan_if #(
  parameter int ROWS     = 3,
  parameter int COLS     = 11,
  parameter int PWM_BITS = 8
);
  logic                enable;
  logic                wr_en;
  logic [1:0]          wr_row;
  logic [3:0]          wr_col;
  logic [PWM_BITS-1:0] wr_data;
  logic [COLS-1:0]     ledc;
  logic [ROWS-1:0]     leda;
  logic                frame_start;

  modport master (
    output enable, wr_en, wr_row, wr_col, wr_data,
    input  ledc, leda, frame_start
  );

  modport slave (
    input  enable, wr_en, wr_row, wr_col, wr_data,
    output ledc, leda, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/led_matrix_scan.sv
// ---------------------------------------------------------------------------
// Module   : led_matrix_scan
// Purpose  : Row-scanned PWM driver for a ROWS x COLS LED matrix. Holds a
//            brightness frame buffer, scans one row at a time with an all-off
//            blanking gap before each row, and PWMs the columns of the active
//            row from a shadow copy latched at the start of the row.
// Ports    : clk   - system clock
//            rst_n - asynchronous active-low reset
//            bus   - led_matrix_scan_if.slave (enable, pixel write port,
//                    ledc/leda drive, frame_start)
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module led_matrix_scan #(
  parameter int ROWS        = 3,
  parameter int COLS        = 11,
  parameter int PWM_BITS    = 8,
  parameter int PRESCALE    = 4,
  parameter int BLANK_TICKS = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  led_matrix_scan_if.slave  bus
);

  localparam int ROW_W = (ROWS > 1)        ? $clog2(ROWS)        : 1;
  localparam int PS_W  = (PRESCALE > 1)    ? $clog2(PRESCALE)    : 1;
  localparam int BT_W  = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_BLANK = 2'd1;
  localparam logic [1:0] c_ON    = 2'd2;

  localparam logic [PWM_BITS-1:0] c_PWM_LAST = {PWM_BITS{1'b1}} - 1'b1;
  localparam logic [PS_W-1:0]     c_PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [BT_W-1:0]     c_BT_LAST  = BT_W'(BLANK_TICKS - 1);
  localparam logic [ROW_W-1:0]    c_ROW_LAST = ROW_W'(ROWS - 1);

  logic [1:0]          r_state;
  logic [ROW_W-1:0]    r_row;
  logic [PS_W-1:0]     r_presc;
  logic [BT_W-1:0]     r_tick_cnt;
  logic [PWM_BITS-1:0] r_pwm;
  logic [PWM_BITS-1:0] r_fb     [ROWS][COLS];
  logic [PWM_BITS-1:0] r_shadow [COLS];
  logic [COLS-1:0]     r_ledc;
  logic [ROWS-1:0]     r_leda;
  logic                r_fs;

  logic                w_tick;
  logic                w_wr_ok;
  logic [COLS-1:0]     w_ledc_cmp;
  logic [ROWS-1:0]     w_onehot;

  assign w_tick   = (r_presc == c_PS_LAST);
  assign w_wr_ok  = bus.wr_en && (32'(bus.wr_row) < ROWS) && (32'(bus.wr_col) < COLS);
  assign w_onehot = ROWS'(1) << r_row;

  always_comb begin
    w_ledc_cmp = '0;
    for (int c = 0; c < COLS; c++) begin
      w_ledc_cmp[c] = (r_shadow[c] > r_pwm);
    end
  end

  // Frame buffer: out-of-range addresses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          r_fb[r][c] <= '0;
        end
      end
    end else if (w_wr_ok) begin
      r_fb[bus.wr_row][bus.wr_col] <= bus.wr_data;
    end
  end

  // Scan FSM. The prescaler free-runs outside IDLE and wraps on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_row      <= '0;
      r_presc    <= '0;
      r_tick_cnt <= '0;
      r_pwm      <= '0;
      for (int c = 0; c < COLS; c++) begin
        r_shadow[c] <= '0;
      end
    end else if (!bus.enable) begin
      r_state    <= c_IDLE;
      r_row      <= '0;
      r_presc    <= '0;
      r_tick_cnt <= '0;
      r_pwm      <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_state    <= c_BLANK;
          r_row      <= '0;
          r_presc    <= '0;
          r_tick_cnt <= '0;
          r_pwm      <= '0;
        end
        c_BLANK: begin
          r_presc <= w_tick ? '0 : r_presc + 1'b1;
          if (w_tick) begin
            if (r_tick_cnt == c_BT_LAST) begin
              r_state    <= c_ON;
              r_tick_cnt <= '0;
              r_pwm      <= '0;
              // Row contents are frozen for the whole ON period so a write
              // mid-row cannot tear the displayed row.
              for (int c = 0; c < COLS; c++) begin
                r_shadow[c] <= r_fb[r_row][c];
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        c_ON: begin
          r_presc <= w_tick ? '0 : r_presc + 1'b1;
          if (w_tick) begin
            if (r_pwm == c_PWM_LAST) begin
              r_state <= c_BLANK;
              r_pwm   <= '0;
              r_row   <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
              r_pwm <= r_pwm + 1'b1;
            end
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Registered outputs, one clk behind the FSM. The first BLANK cycle of a
  // row is the only one with prescaler and tick counter both zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ledc <= '0;
      r_leda <= '0;
      r_fs   <= 1'b0;
    end else begin
      r_fs   <= (r_state == c_BLANK) && (r_row == '0) &&
                (r_presc == '0) && (r_tick_cnt == '0);
      r_leda <= (r_state == c_ON) ? w_onehot   : '0;
      r_ledc <= (r_state == c_ON) ? w_ledc_cmp : '0;
    end
  end

  assign bus.ledc        = r_ledc;
  assign bus.leda        = r_leda;
  assign bus.frame_start = r_fs;

endmodule

`default_nettype wire

// File: tb/tb_led_matrix_scan.sv
// ---------------------------------------------------------------------------
// Module   : tb_led_matrix_scan
// Purpose  : Self-checking bench for led_matrix_scan. A time-position model
//            predicts every output cycle; table vectors and directed
//            sequences check brightness, frame timing, tearing, disable and
//            asynchronous reset.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_led_matrix_scan;

  localparam int ROWS        = 3;
  localparam int COLS        = 11;
  localparam int PWM_BITS    = 8;
  localparam int PRESCALE    = 4;
  localparam int BLANK_TICKS = 4;
  localparam int BLANK_CLKS  = BLANK_TICKS * PRESCALE;
  localparam int ON_CLKS     = ((1 << PWM_BITS) - 1) * PRESCALE;
  localparam int ROW_P       = BLANK_CLKS + ON_CLKS;
  localparam int FRAME_P     = ROWS * ROW_P;

  logic clk;
  logic rst_n;

  led_matrix_scan_if #(.ROWS(ROWS), .COLS(COLS), .PWM_BITS(PWM_BITS)) bus ();

  led_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS), .PWM_BITS(PWM_BITS),
    .PRESCALE(PRESCALE), .BLANK_TICKS(BLANK_TICKS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Position p = clocks since the enable edge, modulo the frame period;
  // -1 means idle. Outputs after an edge show the position before it.
  int                  pos;
  logic [PWM_BITS-1:0] mb [ROWS][COLS];
  logic [PWM_BITS-1:0] sh [ROWS][COLS];
  logic [COLS-1:0]     e_ledc;
  logic [ROWS-1:0]     e_leda;
  logic                e_fs;

  function automatic int f_next(input int p, input logic en);
    if (!en)   return -1;
    if (p < 0) return 0;
    return (p + 1) % FRAME_P;
  endfunction

  function automatic logic [ROWS-1:0] f_leda(input int p);
    if (p < 0 || (p % ROW_P) < BLANK_CLKS) return '0;
    return ROWS'(1) << (p / ROW_P);
  endfunction

  function automatic logic [COLS-1:0] f_ledc(input int p);
    logic [COLS-1:0] v;
    int r, idx;
    v = '0;
    if (p >= 0 && (p % ROW_P) >= BLANK_CLKS) begin
      r   = p / ROW_P;
      idx = ((p % ROW_P) - BLANK_CLKS) / PRESCALE;
      for (int c = 0; c < COLS; c++) v[c] = (int'(sh[r][c]) > idx);
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos    <= -1;
      e_ledc <= '0;
      e_leda <= '0;
      e_fs   <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          mb[r][c] <= '0;
          sh[r][c] <= '0;
        end
    end else begin
      e_ledc <= f_ledc(pos);
      e_leda <= f_leda(pos);
      e_fs   <= (pos == 0);
      pos    <= f_next(pos, bus.enable);
      if (f_next(pos, bus.enable) >= 0 &&
          (f_next(pos, bus.enable) % ROW_P) == BLANK_CLKS)
        for (int c = 0; c < COLS; c++)
          sh[f_next(pos, bus.enable) / ROW_P][c] <= mb[f_next(pos, bus.enable) / ROW_P][c];
      if (bus.wr_en && int'(bus.wr_row) < ROWS && int'(bus.wr_col) < COLS)
        mb[bus.wr_row][bus.wr_col] <= bus.wr_data;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      n_total++;
      if (bus.ledc === e_ledc && bus.leda === e_leda && bus.frame_start === e_fs)
        n_pass++;
      else
        $display("FAIL cycle: got ledc=%b leda=%b fs=%b expected ledc=%b leda=%b fs=%b at %0t",
                 bus.ledc, bus.leda, bus.frame_start, e_ledc, e_leda, e_fs, $time);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] row;
    logic [3:0] col;
    logic [7:0] data;
    int         mrow;
    int         mcol;
    int         exp_clks;
  } vec_t;

  vec_t tab [8];
  int   cnt [8];
  int   leda1_cnt, dark, min_gap, first_lit;
  logic [ROWS-1:0] prev_leda;
  int   order_q [$];

  task automatic wr(input logic [1:0] r, input logic [3:0] c, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_row  = r;
    bus.wr_col  = c;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic samp(input int i);
    for (int k = 0; k < 8; k++)
      if (bus.leda == (ROWS'(1) << tab[k].mrow) && bus.ledc[tab[k].mcol]) cnt[k]++;
    if (bus.leda == 3'b010) leda1_cnt++;
    if (bus.leda != '0 && first_lit < 0) first_lit = i;
    if (bus.leda != '0 && bus.leda != prev_leda) begin
      order_q.push_back(int'(bus.leda));
      if (prev_leda != '0) min_gap = 0;
      else if (dark < min_gap) min_gap = dark;
    end
    if (bus.leda == '0 && bus.ledc == '0) dark++;
    else dark = 0;
    prev_leda = bus.leda;
  endtask

  // Precondition: the current negedge sample shows frame_start=1.
  task automatic run_frame();
    for (int k = 0; k < 8; k++) cnt[k] = 0;
    leda1_cnt = 0; dark = 0; min_gap = 1 << 30; first_lit = -1;
    prev_leda = '0;
    order_q.delete();
    for (int i = 0; i < FRAME_P; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) chk("fs_width", int'(bus.frame_start), 0);
      samp(i);
    end
    @(negedge clk);
    chk("fs_period", int'(bus.frame_start), 1);
  endtask

  task automatic wait_leda(input logic [ROWS-1:0] v);
    int n;
    n = 0;
    while (bus.leda != v && n < 2 * FRAME_P) begin
      @(negedge clk);
      n++;
    end
    if (bus.leda != v) chk("leda_timeout", int'(bus.leda), int'(v));
  endtask

  int n, tear;

  initial begin
    tab[0] = '{2'd1, 4'd5,  8'd128, 1, 5,  512};
    tab[1] = '{2'd0, 4'd0,  8'd0,   0, 0,  0};
    tab[2] = '{2'd2, 4'd10, 8'd255, 2, 10, 1020};
    tab[3] = '{2'd0, 4'd3,  8'd10,  0, 3,  40};
    tab[4] = '{2'd2, 4'd1,  8'd1,   2, 1,  4};
    tab[5] = '{2'd1, 4'd0,  8'd254, 1, 0,  1016};
    tab[6] = '{2'd3, 4'd4,  8'd77,  0, 4,  0};
    tab[7] = '{2'd1, 4'd11, 8'd77,  1, 10, 0};

    rst_n       = 1'b0;
    bus.enable  = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_row  = '0;
    bus.wr_col  = '0;
    bus.wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ledc", int'(bus.ledc), 0);
    chk("rst_leda", int'(bus.leda), 0);
    chk("rst_fs",   int'(bus.frame_start), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 8; k++) wr(tab[k].row, tab[k].col, tab[k].data);
    repeat (50) @(negedge clk);
    chk("idle_leda", int'(bus.leda), 0);

    // First frame latency and contents.
    bus.enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_start && n < 4000);
    chk("fs_first_latency", n, 2);
    run_frame();
    for (int k = 0; k < 8; k++) chk($sformatf("vec%0d_clks", k), cnt[k], tab[k].exp_clks);
    chk("row1_window", leda1_cnt, ON_CLKS);
    chk("first_lit", first_lit, BLANK_CLKS);
    chk("row_count", order_q.size(), 3);
    if (order_q.size() == 3) begin
      chk("row_order0", order_q[0], 1);
      chk("row_order1", order_q[1], 2);
      chk("row_order2", order_q[2], 4);
    end
    chk("min_gap_ok", int'(min_gap >= BLANK_CLKS), 1);

    // Tearing: rewrite [0][3] during row 0 ON.
    wait_leda(3'b001);
    tear = 0;
    bus.wr_en = 1'b1; bus.wr_row = 2'd0; bus.wr_col = 4'd3; bus.wr_data = 8'd200;
    if (bus.ledc[3]) tear++;
    for (int i = 0; i < 2 * ROW_P; i++) begin
      @(negedge clk);
      bus.wr_en = 1'b0;
      if (bus.leda != 3'b001) break;
      if (bus.ledc[3]) tear++;
    end
    chk("tear_current", tear, 40);
    wait_leda(3'b001);
    tear = 0;
    for (int i = 0; i < 2 * ROW_P; i++) begin
      if (bus.leda != 3'b001) break;
      if (bus.ledc[3]) tear++;
      @(negedge clk);
    end
    chk("tear_next", tear, 800);

    // Disable mid row 1, then restart.
    wait_leda(3'b010);
    repeat (100) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("dis_leda", int'(bus.leda), 0);
    chk("dis_ledc", int'(bus.ledc), 0);
    repeat (20) @(negedge clk);
    bus.enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reen_fs", int'(bus.frame_start), 1);
    run_frame();
    chk("reen_px15", cnt[0], 512);
    chk("reen_px210", cnt[2], 1020);
    chk("reen_px03", cnt[3], 800);

    // Random writes (including invalid addresses) and brief enable drops.
    for (int i = 0; i < 15000; i++) begin
      bus.enable  = ($urandom_range(0, 3999) != 0);
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_row  = 2'($urandom_range(0, 3));
      bus.wr_col  = 4'($urandom_range(0, 11));
      bus.wr_data = 8'($urandom);
      @(negedge clk);
    end
    bus.wr_en  = 1'b0;
    bus.enable = 1'b1;

    // Asynchronous reset in the middle of an ON row.
    wait_leda(3'b100);
    repeat (50) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ledc", int'(bus.ledc), 0);
    chk("arst_leda", int'(bus.leda), 0);
    bus.enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5000) @(negedge clk);
    chk("post_rst_leda", int'(bus.leda), 0);
    chk("post_rst_ledc", int'(bus.ledc), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
